counter_cycle_scheduler: RTL and testbench

- Schedules counter-increment memory cycles. It shares the memory cycle (MCT) that the timer sequences between instruction execution and counter-cell requests (PINC/MINC).
- Latches per-cell increment/decrement requests and resolves them by fixed priority.
- At each end-of-MCT strobe (T12 timepulse) it decides whether the next MCT is stolen for a counter cycle, and for which cell and direction.
- Sits between the timer (T12, GOJAM, STOP) and the counter/sequence-generator logic.

---
 rtl/counter_cycle_scheduler.sv | 156 +++++++++++++++
 tb/tb_counter_cycle_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/counter_cycle_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : counter_cycle_scheduler
// Brief    : Latches per-cell PINC/MINC requests and, at each end-of-MCT strobe,
//            decides whether the next MCT is stolen for a counter cycle.
// Revision : 1.0  initial release
// ============================================================================
module counter_cycle_scheduler #(
    parameter int NCELLS   = 16,
    parameter int IDXW     = 4,
    parameter int MAXSTEAL = 4
) (
    input  logic              CLOCK,
    input  logic              SIM_RST,
    input  logic              T12_STB,
    input  logic              GOJAM,
    input  logic              INHINC,
    input  logic [NCELLS-1:0] PINC_REQ,
    input  logic [NCELLS-1:0] MINC_REQ,
    output logic              CTR_CYCLE,
    output logic [IDXW-1:0]   CELL_IDX,
    output logic              PINC,
    output logic              MINC,
    output logic [NCELLS-1:0] GRANT,
    output logic              PEND_ANY,
    output logic              OVERRUN
);

    localparam int SCW = (MAXSTEAL > 0) ? $clog2(MAXSTEAL + 1) : 1;
    localparam logic [SCW-1:0] C_MAXSTEAL = SCW'(MAXSTEAL);

    typedef enum logic [0:0] {ST_INST = 1'b0, ST_CTR = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [NCELLS-1:0] r_prev_p, r_prev_m;
    logic [NCELLS-1:0] r_pend_p, r_pend_m;   // per-cell state: PLUS / MINUS / neither
    logic [NCELLS-1:0] r_grant;
    logic [IDXW-1:0]   r_cell_idx;
    logic              r_pinc, r_minc, r_pend_any, r_overrun;
    logic [SCW-1:0]    r_steal;

    logic [NCELLS-1:0] w_rise_p, w_rise_m, w_pend_vec, w_clr;
    logic [NCELLS-1:0] w_nxt_p, w_nxt_m, w_ovr;
    logic [IDXW-1:0]   w_sel;
    logic              w_sel_plus, w_eligible, w_take;

    // Requests are ignored while GOJAM is high, but the history keeps tracking.
    assign w_rise_p   = PINC_REQ & ~r_prev_p & {NCELLS{~GOJAM}};
    assign w_rise_m   = MINC_REQ & ~r_prev_m & {NCELLS{~GOJAM}};
    assign w_pend_vec = r_pend_p | r_pend_m;
    assign w_eligible = r_pend_any & ~INHINC &
                        ~((MAXSTEAL != 0) && (r_steal == C_MAXSTEAL));
    assign w_take     = T12_STB & w_eligible;

    // Lowest index wins, so scan from the top and let lower hits overwrite.
    always_comb begin
        w_sel      = '0;
        w_sel_plus = 1'b0;
        for (int i = NCELLS - 1; i >= 0; i--) begin
            if (w_pend_vec[i]) begin
                w_sel      = IDXW'(i);
                w_sel_plus = r_pend_p[i];
            end
        end
    end

    assign w_clr = w_take ? (NCELLS'(1) << w_sel) : '0;

    // Grant clear is applied first, then this cycle's rises on top of it.
    generate
        for (genvar g = 0; g < NCELLS; g++) begin : g_cell
            logic w_base_p, w_base_m, w_rp, w_rm;
            assign w_base_p = r_pend_p[g] & ~w_clr[g];
            assign w_base_m = r_pend_m[g] & ~w_clr[g];
            assign w_rp     = w_rise_p[g] & ~w_rise_m[g];
            assign w_rm     = w_rise_m[g] & ~w_rise_p[g];
            assign w_nxt_p[g] = w_rp ? ~w_base_m : (w_rm ? 1'b0 : w_base_p);
            assign w_nxt_m[g] = w_rm ? ~w_base_p : (w_rp ? 1'b0 : w_base_m);
            assign w_ovr[g]   = (w_rp & w_base_p) | (w_rm & w_base_m);
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        if (GOJAM) begin
            w_state_nxt = ST_INST;
        end else if (T12_STB) begin
            w_state_nxt = w_eligible ? ST_CTR : ST_INST;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            r_state <= ST_INST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            r_prev_p   <= '1;
            r_prev_m   <= '1;
            r_pend_p   <= '0;
            r_pend_m   <= '0;
            r_grant    <= '0;
            r_cell_idx <= '0;
            r_pinc     <= 1'b0;
            r_minc     <= 1'b0;
            r_pend_any <= 1'b0;
            r_overrun  <= 1'b0;
            r_steal    <= '0;
        end else begin
            r_prev_p <= PINC_REQ;
            r_prev_m <= MINC_REQ;
            if (GOJAM) begin
                r_pend_p   <= '0;
                r_pend_m   <= '0;
                r_grant    <= '0;
                r_pinc     <= 1'b0;
                r_minc     <= 1'b0;
                r_pend_any <= 1'b0;
                r_overrun  <= 1'b0;
                r_steal    <= '0;
            end else begin
                r_pend_p   <= w_nxt_p;
                r_pend_m   <= w_nxt_m;
                r_pend_any <= |(w_nxt_p | w_nxt_m);
                r_overrun  <= r_overrun | (|w_ovr);
                r_grant    <= w_clr;
                if (w_take) begin
                    r_cell_idx <= w_sel;
                    r_pinc     <= w_sel_plus;
                    r_minc     <= ~w_sel_plus;
                    if ((MAXSTEAL != 0) && (r_steal != C_MAXSTEAL)) begin
                        r_steal <= r_steal + 1'b1;
                    end
                end else if (T12_STB) begin
                    r_pinc  <= 1'b0;
                    r_minc  <= 1'b0;
                    r_steal <= '0;
                end
            end
        end
    end

    assign CTR_CYCLE = (r_state == ST_CTR);
    assign CELL_IDX  = r_cell_idx;
    assign PINC      = r_pinc;
    assign MINC      = r_minc;
    assign GRANT     = r_grant;
    assign PEND_ANY  = r_pend_any;
    assign OVERRUN   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_counter_cycle_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_cycle_scheduler
// Brief    : Directed self-checking bench for counter_cycle_scheduler.
// Revision : 1.0  initial release
// ============================================================================
module tb_counter_cycle_scheduler;

    logic        clk = 1'b0;
    logic        rst, t12, gojam, inhinc;
    logic [15:0] preq, mreq;
    logic        ctr, pinc, minc, pend_any, overrun;
    logic [3:0]  cell_idx;
    logic [15:0] grant;
    int          n_tests = 0;
    int          n_fail  = 0;

    counter_cycle_scheduler #(.NCELLS(16), .IDXW(4), .MAXSTEAL(4)) dut (
        .CLOCK(clk), .SIM_RST(rst), .T12_STB(t12), .GOJAM(gojam), .INHINC(inhinc),
        .PINC_REQ(preq), .MINC_REQ(mreq), .CTR_CYCLE(ctr), .CELL_IDX(cell_idx),
        .PINC(pinc), .MINC(minc), .GRANT(grant), .PEND_ANY(pend_any), .OVERRUN(overrun)
    );

    initial forever #5 clk = ~clk;

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        t12 = 1'b1;
        tick();
        t12 = 1'b0;
    endtask

    task automatic test_reset();
        preq = 16'h0008;
        rst  = 1'b1;
        tick(); tick();
        n_tests++; if (pend_any !== 1'b0) begin n_fail++; $display("FAIL rst_pend got=%b exp=0", pend_any); end
        n_tests++; if (ctr !== 1'b0) begin n_fail++; $display("FAIL rst_ctr got=%b exp=0", ctr); end
        n_tests++; if (grant !== 16'h0) begin n_fail++; $display("FAIL rst_grant got=%h exp=0000", grant); end
        n_tests++; if ({cell_idx, pinc, minc, overrun} !== 7'b0) begin n_fail++; $display("FAIL rst_outs got=%b exp=0", {cell_idx, pinc, minc, overrun}); end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            strobe();
            n_tests++; if ({ctr, pend_any} !== 2'b00) begin n_fail++; $display("FAIL rst_held_req s%0d got=%b exp=00", k, {ctr, pend_any}); end
        end
        preq = 16'h0;
        tick();
    endtask

    task automatic test_priority();
        preq[5] = 1'b1; mreq[2] = 1'b1;
        tick();
        preq = 16'h0; mreq = 16'h0;
        n_tests++; if (pend_any !== 1'b1) begin n_fail++; $display("FAIL prio_pend got=%b exp=1", pend_any); end
        strobe();
        n_tests++; if (grant !== 16'h0004) begin n_fail++; $display("FAIL prio_g1 got=%h exp=0004", grant); end
        n_tests++; if ({ctr, cell_idx, pinc, minc} !== {1'b1, 4'd2, 1'b0, 1'b1}) begin n_fail++; $display("FAIL prio_c1 got=%b exp=1001001", {ctr, cell_idx, pinc, minc}); end
        tick();
        n_tests++; if (grant !== 16'h0) begin n_fail++; $display("FAIL prio_gpulse got=%h exp=0000", grant); end
        n_tests++; if ({ctr, cell_idx, minc} !== {1'b1, 4'd2, 1'b1}) begin n_fail++; $display("FAIL prio_hold got=%b exp=100101", {ctr, cell_idx, minc}); end
        strobe();
        n_tests++; if (grant !== 16'h0020) begin n_fail++; $display("FAIL prio_g2 got=%h exp=0020", grant); end
        n_tests++; if ({ctr, cell_idx, pinc, minc, pend_any} !== {1'b1, 4'd5, 1'b1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL prio_c2 got=%b exp=101011 0", {ctr, cell_idx, pinc, minc, pend_any}); end
        strobe();
        n_tests++; if ({ctr, pinc, minc, grant} !== 19'h0) begin n_fail++; $display("FAIL prio_inst got=%b exp=0", {ctr, pinc, minc, grant}); end
        n_tests++; if (cell_idx !== 4'd5) begin n_fail++; $display("FAIL prio_idx_hold got=%0d exp=5", cell_idx); end
    endtask

    task automatic test_cancel_overrun();
        preq[7] = 1'b1; tick(); preq[7] = 1'b0;
        mreq[7] = 1'b1; tick(); mreq[7] = 1'b0;
        n_tests++; if (pend_any !== 1'b0) begin n_fail++; $display("FAIL cancel_pend got=%b exp=0", pend_any); end
        strobe();
        n_tests++; if ({ctr, overrun} !== 2'b00) begin n_fail++; $display("FAIL cancel_ctr got=%b exp=00", {ctr, overrun}); end
        // Simultaneous P and M rises on one cell net to nothing.
        preq[8] = 1'b1; mreq[8] = 1'b1; tick(); preq[8] = 1'b0; mreq[8] = 1'b0;
        n_tests++; if ({pend_any, overrun} !== 2'b00) begin n_fail++; $display("FAIL netzero got=%b exp=00", {pend_any, overrun}); end
        preq[7] = 1'b1; tick(); preq[7] = 1'b0; tick(); preq[7] = 1'b1; tick(); preq[7] = 1'b0;
        n_tests++; if ({overrun, pend_any} !== 2'b11) begin n_fail++; $display("FAIL ovr_set got=%b exp=11", {overrun, pend_any}); end
        strobe();
        n_tests++; if ({grant, pinc, cell_idx} !== {16'h0080, 1'b1, 4'd7}) begin n_fail++; $display("FAIL ovr_grant got=%h/%b/%0d exp=0080/1/7", grant, pinc, cell_idx); end
        strobe();
        n_tests++; if ({ctr, grant, overrun} !== {1'b0, 16'h0, 1'b1}) begin n_fail++; $display("FAIL ovr_once got=%b/%h/%b exp=0/0000/1", ctr, grant, overrun); end
    endtask

    task automatic test_maxsteal();
        logic [5:0] exp_ctr;
        logic [3:0] exp_idx [6];
        exp_ctr = 6'b101111;   // bit k = strobe k+1
        exp_idx = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4};
        preq[5:0] = 6'h3F; tick(); preq = 16'h0;
        for (int k = 0; k < 6; k++) begin
            strobe();
            n_tests++; if ({ctr, cell_idx} !== {exp_ctr[k], exp_idx[k]}) begin n_fail++; $display("FAIL steal_s%0d got=%b/%0d exp=%b/%0d", k + 1, ctr, cell_idx, exp_ctr[k], exp_idx[k]); end
        end
        strobe();
        n_tests++; if ({ctr, cell_idx, grant} !== {1'b1, 4'd5, 16'h0020}) begin n_fail++; $display("FAIL steal_last got=%b/%0d/%h exp=1/5/0020", ctr, cell_idx, grant); end
        strobe();
        n_tests++; if ({ctr, pend_any} !== 2'b00) begin n_fail++; $display("FAIL steal_done got=%b exp=00", {ctr, pend_any}); end
    endtask

    task automatic test_inhinc();
        mreq[1] = 1'b1; tick(); mreq[1] = 1'b0;
        inhinc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            strobe();
            n_tests++; if ({ctr, pend_any, grant} !== {1'b0, 1'b1, 16'h0}) begin n_fail++; $display("FAIL inh_s%0d got=%b/%b/%h exp=0/1/0000", k, ctr, pend_any, grant); end
        end
        inhinc = 1'b0;
        strobe();
        n_tests++; if ({grant, ctr, cell_idx, minc} !== {16'h0002, 1'b1, 4'd1, 1'b1}) begin n_fail++; $display("FAIL inh_release got=%h/%b/%0d/%b exp=0002/1/1/1", grant, ctr, cell_idx, minc); end
        strobe();
    endtask

    task automatic test_gojam();
        preq[12:10] = 3'b111; tick(); preq = 16'h0;
        strobe();
        n_tests++; if ({ctr, cell_idx} !== {1'b1, 4'd10}) begin n_fail++; $display("FAIL gj_pre got=%b/%0d exp=1/10", ctr, cell_idx); end
        gojam = 1'b1; t12 = 1'b1;   // GOJAM beats a coincident strobe
        tick();
        gojam = 1'b0; t12 = 1'b0;
        n_tests++; if ({ctr, pend_any, overrun, pinc, minc, grant} !== 21'h0) begin n_fail++; $display("FAIL gj_clear got=%b/%b/%b/%b/%b/%h exp=0", ctr, pend_any, overrun, pinc, minc, grant); end
        strobe();
        n_tests++; if ({ctr, grant} !== 17'h0) begin n_fail++; $display("FAIL gj_nogrant got=%b/%h exp=0/0000", ctr, grant); end
        // A rise masked by GOJAM is absorbed into the history and never captured.
        gojam = 1'b1; preq[9] = 1'b1; tick(); gojam = 1'b0; tick();
        n_tests++; if (pend_any !== 1'b0) begin n_fail++; $display("FAIL gj_mask got=%b exp=0", pend_any); end
        preq[9] = 1'b0; tick();
    endtask

    task automatic test_back_to_back();
        preq[0] = 1'b1; tick(); preq[0] = 1'b0; tick();
        preq[0] = 1'b1;
        strobe();
        preq[0] = 1'b0;
        n_tests++; if ({grant, pinc, pend_any, overrun} !== {16'h0001, 1'b1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL coll_grant got=%h/%b/%b/%b exp=0001/1/1/0", grant, pinc, pend_any, overrun); end
        strobe();
        n_tests++; if ({grant, ctr, pend_any} !== {16'h0001, 1'b1, 1'b0}) begin n_fail++; $display("FAIL coll_regrant got=%h/%b/%b exp=0001/1/0", grant, ctr, pend_any); end
        strobe();
        // Rise on the strobe edge itself waits for the following strobe.
        preq[6] = 1'b1;
        strobe();
        preq[6] = 1'b0;
        n_tests++; if ({ctr, pend_any, grant} !== {1'b0, 1'b1, 16'h0}) begin n_fail++; $display("FAIL late_rise got=%b/%b/%h exp=0/1/0000", ctr, pend_any, grant); end
        strobe();
        n_tests++; if ({grant, cell_idx, pinc} !== {16'h0040, 4'd6, 1'b1}) begin n_fail++; $display("FAIL late_grant got=%h/%0d/%b exp=0040/6/1", grant, cell_idx, pinc); end
    endtask

    initial begin
        rst = 1'b1; t12 = 1'b0; gojam = 1'b0; inhinc = 1'b0;
        preq = 16'h0; mreq = 16'h0;
        test_reset();
        test_priority();
        test_cancel_overrun();
        test_maxsteal();
        test_inhinc();
        test_gojam();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
